// File: rtl/fir_to_posit_pipe_if.sv
// FIR-in / posit-out handshake bundle for fir_to_posit_pipe.
// master drives the FIR operands and consumes the posit; slave is the encoder.
interface fir_to_posit_pipe_if #(
  parameter int N  = 16,
  parameter int ES = 1
);
  localparam int S       = $clog2(N);
  localparam int TE_SIZE = (ES + 1) + (S + 1);
  localparam int MS      = N - 2;

  logic               in_valid;
  logic               in_ready;
  logic               sign;
  logic [TE_SIZE-1:0] te;
  logic [MS-1:0]      mant;
  logic [MS-1:0]      ext;
  logic               sticky;
  logic               is_zero;
  logic               is_nar;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       posit;

  modport master (
    output in_valid, sign, te, mant, ext, sticky, is_zero, is_nar, out_ready,
    input  in_ready, out_valid, posit
  );

  modport slave (
    input  in_valid, sign, te, mant, ext, sticky, is_zero, is_nar, out_ready,
    output in_ready, out_valid, posit
  );
endinterface

// File: rtl/fir_to_posit_pipe.sv
// Two-stage FIR -> posit encoder: stage 1 assembles regime/exp/fraction, stage 2 rounds and applies sign.
// Define PPU_ROUND_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fir_to_posit_pipe #(
  parameter int N  = 16,
  parameter int ES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fir_to_posit_pipe_if.slave bus
);
  localparam int S       = $clog2(N);
  localparam int TE_SIZE = (ES + 1) + (S + 1);
  localparam int MS      = N - 2;
  localparam int WX      = 2 + ES + (MS - 1) + MS + N;
  localparam logic signed [TE_SIZE-1:0] K_MAX = TE_SIZE'(N - 2);
  localparam logic signed [TE_SIZE-1:0] K_MIN = TE_SIZE'(-(N - 1));
  localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

  logic s1_valid, s1_sign, s1_zero, s1_nar;
  logic [N-2:0] s1_u;
  logic s2_adv, s1_adv;

  assign s2_adv      = !bus.out_valid || bus.out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1: regime built by shifting a 10/01 seed; k>=0 back-fills ones from the top.
  logic signed [TE_SIZE-1:0] k;
  logic [TE_SIZE-1:0] sh;
  logic [WX-1:0] base, str;
  logic clamp_max, clamp_min;
  logic [N-2:0] u_n;

  assign k         = $signed(bus.te) >>> ES;
  assign clamp_max = (k >= K_MAX);
  assign clamp_min = (k <= K_MIN);

  always_comb begin
    base = {(k[TE_SIZE-1] ? 2'b01 : 2'b10), bus.te[ES-1:0], bus.mant[MS-2:0], bus.ext, {N{1'b0}}};
    sh   = k[TE_SIZE-1] ? ~k : k;
    str  = base >> sh;
    if (!k[TE_SIZE-1]) str = str | ~({WX{1'b1}} >> sh);
  end

  always_comb begin
    u_n = str[WX-1 -: N-1];
    if (clamp_max)      u_n = '1;
    else if (clamp_min) u_n = ONE[N-2:0];
  end

`ifdef PPU_ROUND_RNE_EN
  logic s1_guard, s1_sticky;
  logic guard_n, sticky_n;
  assign guard_n  = str[WX-N] & ~(clamp_max | clamp_min);
  assign sticky_n = ((|str[WX-N-1:0]) | bus.sticky) & ~(clamp_max | clamp_min);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
    end else if (s1_adv && bus.in_valid) begin
      s1_guard  <= guard_n;
      s1_sticky <= sticky_n;
    end
  end
`else
  logic trunc_unused;
  assign trunc_unused = ^{str[WX-N:0], bus.sticky};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_u     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= bus.sign;
        s1_zero <= bus.is_zero;
        s1_nar  <= bus.is_nar;
        s1_u    <= u_n;
      end
    end
  end

  // Stage 2: round, saturate so a nonzero result never becomes 0 or NaR, then negate.
  logic round_up;
  logic [N-1:0] sum, mag, result;

`ifdef PPU_ROUND_RNE_EN
  assign round_up = s1_guard & (s1_u[0] | s1_sticky);
`else
  assign round_up = 1'b0;
`endif

  assign sum = {1'b0, s1_u} + {{(N-1){1'b0}}, round_up};

  always_comb begin
    mag = sum;
    if (sum[N-1])      mag = MAXPOS;
    else if (sum == '0) mag = ONE;
    if (s1_nar)        result = NAR;
    else if (s1_zero)  result = '0;
    else if (s1_sign)  result = ~mag + ONE;
    else               result = mag;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.out_valid <= 1'b0;
      bus.posit     <= '0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) bus.posit <= result;
    end
  end
endmodule

// File: tb/tb_fir_to_posit_pipe.sv
// Self-checking bench for fir_to_posit_pipe (N=16, ES=1): vector table, corner sequences, random scoreboard.
module tb_fir_to_posit_pipe;
  typedef struct {
    logic        sign;
    logic [6:0]  te;
    logic [13:0] mant;
    logic [13:0] ext;
    logic        sticky;
    logic        zero;
    logic        nar;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_to_posit_pipe_if #(.N(16), .ES(1)) bus ();
  fir_to_posit_pipe #(.N(16), .ES(1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0, failures = 0;
  int acc_cnt = 0, out_cnt = 0;
  logic [15:0] q[$];
  logic hold = 1'b0;
  logic [15:0] hold_val = '0;

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic sg, input int te, input logic [13:0] m, input logic [13:0] e,
                              input logic st, input logic z, input logic n, input logic [15:0] x);
    vec_t v;
    v.sign = sg; v.te = 7'(te); v.mant = m; v.ext = e;
    v.sticky = st; v.zero = z; v.nar = n; v.exp = x;
    return v;
  endfunction

  // Bit-serial reference: append regime, exponent, fraction and ext bits one at a time.
  function automatic logic [15:0] ref_enc(input vec_t v);
    logic [63:0] s;
    logic [14:0] u;
    logic [15:0] m;
    logic g, st, ru;
    int p, k, tev;
    if (v.nar) return 16'h8000;
    if (v.zero) return 16'h0000;
    tev = int'($signed(v.te));
    k = tev >>> 1;
    if (k >= 14) m = 16'h7FFF;
    else if (k <= -15) m = 16'h0001;
    else begin
      s = '0; p = 63;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin s[p] = 1'b1; p--; end
        s[p] = 1'b0; p--;
      end else begin
        for (int i = 0; i < -k; i++) begin s[p] = 1'b0; p--; end
        s[p] = 1'b1; p--;
      end
      s[p] = v.te[0]; p--;
      for (int i = 12; i >= 0; i--) begin s[p] = v.mant[i]; p--; end
      for (int i = 13; i >= 0; i--) begin s[p] = v.ext[i]; p--; end
      u = s[63:49]; g = s[48]; st = (|s[47:0]) | v.sticky;
`ifdef PPU_ROUND_RNE_EN
      ru = g & (u[0] | st);
`else
      ru = 1'b0 & g & st;
`endif
      m = {1'b0, u} + {15'b0, ru};
      if (m[15]) m = 16'h7FFF;
      if (m == 16'h0000) m = 16'h0001;
    end
    return v.sign ? (~m + 16'd1) : m;
  endfunction

  function automatic vec_t cur_in();
    vec_t v;
    v.sign = bus.sign; v.te = bus.te; v.mant = bus.mant; v.ext = bus.ext;
    v.sticky = bus.sticky; v.zero = bus.is_zero; v.nar = bus.is_nar; v.exp = '0;
    return v;
  endfunction

  // Monitor at negedge: the values seen here are what the next rising edge transfers.
  always @(negedge clk) begin
    if (rst) begin
      q.delete(); acc_cnt = 0; out_cnt = 0; hold = 1'b0;
    end else begin
      if (hold) begin
        check16("hold_valid", {15'b0, bus.out_valid}, 16'h0001);
        check16("hold_posit", bus.posit, hold_val);
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (q.size() == 0) check_int("sb_unexpected_output", 1, 0);
        else check16("sb_posit", bus.posit, q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        q.push_back(ref_enc(cur_in()));
      end
      hold = bus.out_valid && !bus.out_ready;
      hold_val = bus.posit;
    end
  end

  task automatic drive(input vec_t v);
    bus.sign = v.sign; bus.te = v.te; bus.mant = v.mant; bus.ext = v.ext;
    bus.sticky = v.sticky; bus.is_zero = v.zero; bus.is_nar = v.nar;
  endtask

  task automatic apply_one(input vec_t v, input string nm);
    @(posedge clk); #1;
    drive(v); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check16({nm, "_early"}, {15'b0, bus.out_valid}, 16'h0000);
    @(posedge clk); #1;
    check16({nm, "_valid"}, {15'b0, bus.out_valid}, 16'h0001);
    check16(nm, bus.posit, v.exp);
  endtask

  vec_t tbl[16];
  vec_t bp[4];

  initial begin
    vec_t v;
    int idx, oc0, n_stale;
    logic a;
    logic [15:0] r2003, r2001s, r27, rm27;
`ifdef PPU_ROUND_RNE_EN
    r2003 = 16'h4002; r2001s = 16'h4001; r27 = 16'h7FFF; rm27 = 16'h0002;
`else
    r2003 = 16'h4001; r2001s = 16'h4000; r27 = 16'h7FFE; rm27 = 16'h0001;
`endif
    tbl[0]  = mk(0,   0, 14'h2000, 0, 0, 0, 0, 16'h4000);
    tbl[1]  = mk(1,   0, 14'h2000, 0, 0, 0, 0, 16'hC000);
    tbl[2]  = mk(0,   1, 14'h2000, 0, 0, 0, 0, 16'h5000);
    tbl[3]  = mk(0,  -1, 14'h2000, 0, 0, 0, 0, 16'h3000);
    tbl[4]  = mk(0,  40, 14'h2000, 0, 0, 0, 0, 16'h7FFF);
    tbl[5]  = mk(0, -40, 14'h2000, 0, 0, 0, 0, 16'h0001);
    tbl[6]  = mk(1,   5, 14'h2abc, 0, 1, 0, 1, 16'h8000);
    tbl[7]  = mk(1,   5, 14'h2abc, 0, 1, 1, 0, 16'h0000);
    tbl[8]  = mk(0,   0, 14'h2000, 0, 0, 1, 1, 16'h8000);
    tbl[9]  = mk(0,   0, 14'h2001, 0, 0, 0, 0, 16'h4000);
    tbl[10] = mk(0,   0, 14'h2003, 0, 0, 0, 0, r2003);
    tbl[11] = mk(0,   0, 14'h2001, 0, 1, 0, 0, r2001s);
    tbl[12] = mk(0,  27, 14'h2000, 1, 0, 0, 0, r27);
    tbl[13] = mk(1, -28, 14'h2000, 0, 0, 0, 0, 16'hFFFF);
    tbl[14] = mk(1,  28, 14'h2000, 0, 0, 0, 0, 16'h8001);
    tbl[15] = mk(0, -27, 14'h2001, 0, 0, 0, 0, rm27);
    bp[0] = mk(0, 0, 14'h2000, 0, 0, 0, 0, 16'h4000);
    bp[1] = mk(0, 1, 14'h2000, 0, 0, 0, 0, 16'h5000);
    bp[2] = mk(0, -1, 14'h2000, 0, 0, 0, 0, 16'h3000);
    bp[3] = mk(1, 0, 14'h2000, 0, 0, 0, 0, 16'hC000);

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    check16("rst_out_valid", {15'b0, bus.out_valid}, 16'h0000);
    check16("rst_posit", bus.posit, 16'h0000);
    check16("rst_in_ready", {15'b0, bus.in_ready}, 16'h0001);
    rst = 1'b0;
    @(posedge clk); #1;
    check16("post_rst_in_ready", {15'b0, bus.in_ready}, 16'h0001);
    check16("post_rst_out_valid", {15'b0, bus.out_valid}, 16'h0000);

    for (int i = 0; i < 16; i++) apply_one(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: 4 back-to-back inputs with the consumer stalled for 5 cycles.
    @(posedge clk); #1;
    oc0 = out_cnt;
    bus.out_ready = 1'b0; idx = 0;
    drive(bp[0]); bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk); a = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (a) idx++;
      if (idx < 4) drive(bp[idx]); else bus.in_valid = 1'b0;
    end
    check_int("bp_accepts_stalled", idx, 2);
    check16("bp_in_ready_low", {15'b0, bus.in_ready}, 16'h0000);
    check16("bp_head", bus.posit, bp[0].exp);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk); a = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (a) idx++;
      if (idx < 4) drive(bp[idx]); else bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20 && (q.size() != 0 || bus.out_valid); c++) @(posedge clk);
    #1;
    check_int("bp_accepts", idx, 4);
    check_int("bp_outputs", out_cnt - oc0, 4);

    // Reset with two results in flight.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(bp[1]); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(bp[2]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check16("inflight_valid", {15'b0, bus.out_valid}, 16'h0001);
    rst = 1'b1;
    #1;
    check16("midrst_out_valid", {15'b0, bus.out_valid}, 16'h0000);
    check16("midrst_posit", bus.posit, 16'h0000);
    check16("midrst_in_ready", {15'b0, bus.in_ready}, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n_stale = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid) n_stale++;
    end
    check_int("no_stale_output", n_stale, 0);
    apply_one(tbl[2], "after_rst");

    // Random stream with random consumer stalls against the reference model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      v = mk($urandom_range(0, 1), int'($urandom_range(0, 100)) - 50,
             {1'b1, 13'($urandom)}, 14'($urandom), $urandom_range(0, 1),
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 16'h0);
      drive(v);
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && (q.size() != 0 || bus.out_valid); c++) begin
      @(posedge clk); #1;
    end
    check_int("drain_queue_empty", q.size(), 0);
    check_int("transfers_in_eq_out", out_cnt, acc_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
